// File: rtl/elevator_pkg.sv
// Shared encodings and helpers for the per-cab elevator door controller.
package elevator_pkg;

    localparam logic [1:0] ST_CLOSED  = 2'd0;
    localparam logic [1:0] ST_OPENING = 2'd1;
    localparam logic [1:0] ST_OPEN    = 2'd2;
    localparam logic [1:0] ST_CLOSING = 2'd3;

    localparam int unsigned MAX_FLOORS = 64;

    // Width needed to hold floor numbers 0..floors.
    function automatic int unsigned floor_width(input int unsigned floors);
        return $clog2(floors + 1);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned travel, input int unsigned dwell);
        int unsigned m;
        int unsigned w;
        m = (travel > dwell) ? travel : dwell;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot decode of a 1-based floor number; floor 0 or beyond range yields zero.
    function automatic logic [MAX_FLOORS-1:0] floor_onehot(input int unsigned floor);
        if (floor == 0 || floor > MAX_FLOORS) begin
            return '0;
        end
        return MAX_FLOORS'(1) << (floor - 1);
    endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module elevator_door_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_door_ctrl.sv
// Per-cab door controller: opens at the stopped floor, dwells, closes, and
// reverses a closing door on obstruction or open button.
module elevator_door_ctrl
    import elevator_pkg::*;
#(
    parameter  int unsigned FLOORS       = 6,
    parameter  int unsigned TRAVEL_TICKS = 4,
    parameter  int unsigned DWELL_TICKS  = 10,
    localparam int unsigned FW           = floor_width(FLOORS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FW-1:0]     current_floor,
    input  logic              arrive,
    input  logic              moving,
    input  logic              open_btn,
    input  logic              close_btn,
    input  logic              obstruct,
    output logic [FLOORS-1:0] door,
    output logic              door_open,
    output logic              door_closed,
    output logic [1:0]        state
);

    localparam int unsigned    CW          = cnt_width(TRAVEL_TICKS, DWELL_TICKS);
    localparam logic [CW-1:0]  TRAVEL_LOAD = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0]  DWELL_LOAD  = CW'(DWELL_TICKS - 1);

    logic [1:0]        state_q, state_d;
    logic [FW-1:0]     lat_floor_q, lat_floor_d;
    logic [FLOORS-1:0] door_q, door_d;
    logic              door_open_q, door_open_d;
    logic              door_closed_q, door_closed_d;

    logic              tmr_load;
    logic [CW-1:0]     tmr_load_val;
    logic              tmr_en;
    logic [CW-1:0]     tmr_cnt;
    logic              tmr_zero;

    logic              floor_ok;
    logic              open_req;
    logic              hold_req;

    assign floor_ok = (current_floor != '0) && (current_floor <= FW'(FLOORS));
    assign open_req = (arrive || open_btn) && !moving && floor_ok;
    assign hold_req = obstruct || open_btn;
    assign tmr_en   = (state_q != ST_CLOSED);

    elevator_door_timer #(
        .W (CW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // Next-state, timer control and registered output decode.
    always_comb begin
        state_d      = state_q;
        lat_floor_d  = lat_floor_q;
        tmr_load     = 1'b0;
        tmr_load_val = TRAVEL_LOAD;

        case (state_q)
            ST_CLOSED: begin
                if (open_req) begin
                    lat_floor_d  = current_floor;
                    state_d      = ST_OPENING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TRAVEL_LOAD;
                end
            end
            ST_OPENING: begin
                if (tmr_zero) begin
                    state_d      = ST_OPEN;
                    tmr_load     = 1'b1;
                    tmr_load_val = DWELL_LOAD;
                end
            end
            ST_OPEN: begin
                if (hold_req) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = DWELL_LOAD;
                end else if (close_btn || tmr_zero) begin
                    state_d      = ST_CLOSING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TRAVEL_LOAD;
                end
            end
            ST_CLOSING: begin
                // Reopen takes as long as the door has already spent closing.
                if (hold_req) begin
                    state_d      = ST_OPENING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TRAVEL_LOAD - tmr_cnt;
                end else if (tmr_zero) begin
                    state_d = ST_CLOSED;
                end
            end
            default: begin
                state_d = ST_CLOSED;
            end
        endcase

        door_open_d   = (state_d == ST_OPEN);
        door_closed_d = (state_d == ST_CLOSED);
        door_d        = door_closed_d ? '0 : FLOORS'(floor_onehot(32'(lat_floor_d)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_CLOSED;
            lat_floor_q   <= FW'(1);
            door_q        <= '0;
            door_open_q   <= 1'b0;
            door_closed_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            lat_floor_q   <= lat_floor_d;
            door_q        <= door_d;
            door_open_q   <= door_open_d;
            door_closed_q <= door_closed_d;
        end
    end

    assign state       = state_q;
    assign door        = door_q;
    assign door_open   = door_open_q;
    assign door_closed = door_closed_q;

endmodule

// File: tb/tb_elevator_door_ctrl.sv
// Scoreboard bench for elevator_door_ctrl: stimulus queues the expected
// post-edge outputs, a monitor pops and compares them every cycle.
module tb_elevator_door_ctrl;

    localparam int unsigned FLOORS = 6;
    localparam int unsigned FW     = 3;

    localparam logic [1:0] S_CLOSED  = 2'd0;
    localparam logic [1:0] S_OPENING = 2'd1;
    localparam logic [1:0] S_OPEN    = 2'd2;
    localparam logic [1:0] S_CLOSING = 2'd3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [FW-1:0]     current_floor = '0;
    logic              arrive = 1'b0;
    logic              moving = 1'b0;
    logic              open_btn = 1'b0;
    logic              close_btn = 1'b0;
    logic              obstruct = 1'b0;
    logic [FLOORS-1:0] door;
    logic              door_open;
    logic              door_closed;
    logic [1:0]        state;

    typedef struct {
        string             tag;
        logic [1:0]        st;
        logic [FLOORS-1:0] door;
        logic              dopen;
        logic              dclosed;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic  proto_bad;
    string scen     = "reset";

    elevator_door_ctrl #(
        .FLOORS       (6),
        .TRAVEL_TICKS (4),
        .DWELL_TICKS  (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .current_floor (current_floor),
        .arrive        (arrive),
        .moving        (moving),
        .open_btn      (open_btn),
        .close_btn     (close_btn),
        .obstruct      (obstruct),
        .door          (door),
        .door_open     (door_open),
        .door_closed   (door_closed),
        .state         (state)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [1:0] st, input int fl);
        exp_t r;
        r.tag     = scen;
        r.st      = st;
        r.door    = (st == S_CLOSED) ? '0 : FLOORS'(32'd1 << (fl - 1));
        r.dopen   = (st == S_OPEN);
        r.dclosed = (st == S_CLOSED);
        return r;
    endfunction

    task automatic chk(input string name, input string tag, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s/%s cycle %0d: got %0d expected %0d", tag, name, cyc, act, expv);
        end
    endtask

    // Apply inputs for one cycle and queue the outputs expected after the next edge.
    task automatic step(input int fl, input bit arr, input bit opn, input bit cls,
                        input bit obs, input bit mov, input bit rst,
                        input logic [1:0] es, input int ef);
        @(negedge clock);
        current_floor = FW'(fl);
        arrive        = arr;
        open_btn      = opn;
        close_btn     = cls;
        obstruct      = obs;
        moving        = mov;
        reset         = rst;
        exp_q.push_back(mk(es, ef));
    endtask

    task automatic idle(input int n, input logic [1:0] es, input int ef, input int fl);
        for (int i = 0; i < n; i++) begin
            step(fl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, es, ef);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    always begin
        @(posedge clock);
        proto_bad = moving && (state != S_CLOSED);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            chk("state",       e.tag, int'(state),       int'(e.st));
            chk("door",        e.tag, int'(door),        int'(e.door));
            chk("door_open",   e.tag, int'(door_open),   int'(e.dopen));
            chk("door_closed", e.tag, int'(door_closed), int'(e.dclosed));
            chk("protocol",    e.tag, int'(proto_bad),   0);
        end
    end

    initial begin
        scen = "reset";
        step(1, 0, 0, 0, 0, 0, 1, S_CLOSED, 1);
        idle(6, S_CLOSED, 1, 3);

        scen = "dwell";
        step(3, 1, 0, 0, 0, 0, 0, S_OPENING, 3);
        idle(3, S_OPENING, 3, 5);
        idle(4, S_OPEN, 3, 5);
        step(5, 1, 0, 0, 0, 0, 0, S_OPEN, 3);
        idle(5, S_OPEN, 3, 5);
        idle(4, S_CLOSING, 3, 5);
        idle(2, S_CLOSED, 3, 5);

        scen = "obstruct_open";
        step(2, 1, 0, 0, 0, 0, 0, S_OPENING, 2);
        idle(3, S_OPENING, 2, 2);
        idle(8, S_OPEN, 2, 2);
        step(2, 0, 0, 0, 1, 0, 0, S_OPEN, 2);
        idle(9, S_OPEN, 2, 2);
        idle(4, S_CLOSING, 2, 2);
        idle(1, S_CLOSED, 2, 2);

        scen = "reverse";
        step(4, 1, 0, 0, 0, 0, 0, S_OPENING, 4);
        idle(3, S_OPENING, 4, 4);
        idle(10, S_OPEN, 4, 4);
        idle(3, S_CLOSING, 4, 4);
        step(4, 0, 0, 0, 1, 0, 0, S_OPENING, 4);
        idle(2, S_OPENING, 4, 4);
        idle(10, S_OPEN, 4, 4);
        idle(4, S_CLOSING, 4, 4);
        idle(1, S_CLOSED, 4, 4);

        scen = "ignored";
        step(0, 1, 0, 0, 0, 0, 0, S_CLOSED, 1);
        step(7, 1, 0, 0, 0, 0, 0, S_CLOSED, 1);
        step(2, 0, 1, 0, 0, 1, 0, S_CLOSED, 1);
        step(2, 1, 0, 0, 0, 1, 0, S_CLOSED, 1);
        idle(1, S_CLOSED, 1, 2);

        scen = "close_btn";
        step(6, 0, 1, 0, 0, 0, 0, S_OPENING, 6);
        idle(3, S_OPENING, 6, 6);
        idle(2, S_OPEN, 6, 6);
        step(6, 0, 0, 1, 0, 0, 0, S_CLOSING, 6);
        idle(3, S_CLOSING, 6, 6);
        idle(1, S_CLOSED, 6, 6);

        scen = "close_and_obstruct";
        step(1, 1, 0, 0, 0, 0, 0, S_OPENING, 1);
        idle(3, S_OPENING, 1, 1);
        idle(3, S_OPEN, 1, 1);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 1, 1, 0, 0, S_OPEN, 1);
        end
        step(1, 0, 0, 1, 0, 0, 0, S_CLOSING, 1);
        idle(3, S_CLOSING, 1, 1);
        idle(1, S_CLOSED, 1, 1);

        scen = "reset_mid";
        step(5, 1, 0, 0, 0, 0, 0, S_OPENING, 5);
        idle(1, S_OPENING, 5, 5);
        step(5, 0, 1, 0, 0, 0, 1, S_CLOSED, 1);
        idle(2, S_CLOSED, 1, 5);
        step(5, 1, 0, 0, 0, 0, 0, S_OPENING, 5);
        idle(3, S_OPENING, 5, 5);
        idle(1, S_OPEN, 5, 5);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #2;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_door_ctrl.md
# elevator_door_ctrl

Per-cab door controller for the elevator design, parametrised in floor count and door timing. Opens the door at the floor where the cab has stopped, holds it for a dwell time, and closes it. Honours open/close buttons and an obstruction sensor, and reverses a closing door on demand. Sits between the motion controller, which reports arrival and movement, and the per-floor door actuators, which take a one-hot drive.

## Interface
- `FLOORS`, 6: number of floors (≥2); floors are numbered 1..FLOORS.
- `TRAVEL_TICKS`, 4: clock cycles for a full open or full close stroke (≥1).
- `DWELL_TICKS`, 10: clock cycles the door stays fully open (≥1).
- `FW`, `$clog2(FLOORS+1)`: floor-number width (derived, not overridden).

Ports:
- `clock` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `current_floor` input FW: floor the cab is at, 1-based.
- `arrive` input 1: one-cycle pulse, cab has stopped at `current_floor`.
- `moving` input 1: cab in motion; blocks opening.
- `open_btn` input 1: level, in-cab door-open button.
- `close_btn` input 1: level, in-cab door-close button.
- `obstruct` input 1: level, door-edge obstruction sensor.
- `door` output FLOORS: one-hot; bit k-1 is high while the door at floor k is not fully closed.
- `door_open` output 1: door fully open (OPEN state).
- `door_closed` output 1: door fully closed; motion controller may move only when high.
- `state` output 2: current FSM state, for debug.

## Operation
- States (2-bit): CLOSED=0, OPENING=1, OPEN=2, CLOSING=3. Down-counter `cnt`; floor register `lat_floor`.
- CLOSED: `door`=0, `door_closed`=1.
  - Open request = (`arrive` or `open_btn`) and !`moving` and 1≤`current_floor`≤FLOORS.
  - On an open request: latch `lat_floor`=`current_floor`, go to OPENING, `cnt`=TRAVEL_TICKS-1.
  - An out-of-range floor is ignored and the FSM stays CLOSED.
- OPENING: `door`=onehot(`lat_floor`). When `cnt`==0, go to OPEN with `cnt`=DWELL_TICKS-1; otherwise decrement `cnt`.
- OPEN: `door_open`=1.
  - `obstruct` or `open_btn` reloads `cnt`=DWELL_TICKS-1.
  - Otherwise `close_btn` or `cnt`==0 moves to CLOSING with `cnt`=TRAVEL_TICKS-1.
  - Otherwise decrement `cnt`.
  - Priority: reload over close. Obstruct and close together hold the door open.
- CLOSING: `door`=onehot(`lat_floor`).
  - `obstruct` or `open_btn` reverses to OPENING with `cnt`=TRAVEL_TICKS-1-`cnt`. Reopen time equals the cycles already spent closing.
  - Otherwise, when `cnt`==0, go to CLOSED.
  - Otherwise decrement `cnt`.
- `arrive` outside CLOSED is ignored. `current_floor` changes after latching do not affect `door`.
- `moving` high in any state other than CLOSED is a protocol violation. Behaviour is unchanged; the bench flags it.

## Timing
- Reset values:
  - `state`=CLOSED, `cnt`=0, `lat_floor`=1.
  - Outputs: `door`=0, `door_open`=0, `door_closed`=1.
  - Reset mid-stroke takes effect on the next edge regardless of other inputs.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- `arrive` sampled at edge N: OPENING visible after N, `door_closed` low after N.
- `door_open` rises TRAVEL_TICKS cycles after entering OPENING.
- Without buttons, OPEN lasts exactly DWELL_TICKS cycles and CLOSING lasts exactly TRAVEL_TICKS cycles.
- `close_btn` in OPEN: CLOSING is entered on the next edge.
- `cnt` width: `$clog2(max(TRAVEL_TICKS,DWELL_TICKS))`, minimum 1. There is no wrap, because `cnt` is reloaded before it underflows.

## Structure
- Package `elevator_pkg` holds:
  - state encodings `ST_CLOSED`/`ST_OPENING`/`ST_OPEN`/`ST_CLOSING`;
  - floor-width helper function;
  - one-hot floor decode function.
- Sub-module `elevator_door_timer`: loadable down-counter with ports `load`, `load_val`, `en`, `cnt`, `zero`, parametrised in width.
- FSM and `door` decode stay in the top module.

## Test plan
All scenarios use FLOORS=6, TRAVEL_TICKS=4, DWELL_TICKS=10.
- Reset then idle → `door`=000000, `door_closed`=1, `state`=0 held indefinitely.
- `arrive` with `current_floor`=3 → `door`=000100 one cycle later; `door_open` high cycles 5–14; `door_closed` returns high at cycle 19.
- Same as above, with `obstruct` pulsed at OPEN cycle 8 → dwell restarts; `door_open` stays high 10 cycles after the pulse.
- Full close stroke with `obstruct` asserted on its 3rd cycle → OPENING that lasts 3 cycles, then OPEN.
- `arrive` with `current_floor`=0 or 7 → no state change. `open_btn` with `moving`=1 → no state change.
- `close_btn` on the 2nd OPEN cycle → CLOSING next edge. `close_btn` together with `obstruct` → stays OPEN. `reset` mid-OPENING → CLOSED and `door`=0 next edge.
